led_axil_responder: RTL and testbench

AXI4-Lite slave (responder) that terminates register traffic from the Zynq PS or the AXI4-Lite master BFM and drives the board LEDs. It holds four 32-bit registers and serves one write and one read transaction at a time, each on independent channels. An optional blink engine gates the LED outputs. It sits behind the AXI interconnect in the myLED IP, on the same bus the BFM bench drives.

---
 rtl/led_axil_responder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_led_axil_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_axil_responder.sv
`timescale 1ns/1ps
// AXI4-Lite register slave driving board LEDs: CTRL, MODE, DIV, SCRATCH; optional blink gate (LED_BLINK_EN).
// Latency: BVALID 1 cycle after the later of AW/W handshakes; RVALID 1 cycle after AR handshake.
// Backpressure: one write and one read outstanding; READYs drop until BREADY/RREADY complete the response.
module led_axil_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int LED_WIDTH          = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]            LED
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  // Byte-lane merge: lanes with a clear strobe keep the old contents.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    for (int b = 0; b < SW; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // PROT fields and the byte offset within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Held low through reset so no READY is seen until the first edge after release.
  logic en_q;

  wstate_e         wstate_q, wstate_d;
  logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [2:0]      awidx_q, awidx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [1:0]      bresp_q, bresp_d;

  rstate_e         rstate_q, rstate_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;

  logic [DW-1:0]   ctrl_q, ctrl_d, scratch_q, scratch_d;
`ifdef LED_BLINK_EN
  logic            mode_q, mode_d;
  logic [31:0]     div_q, div_d, cnt_q, cnt_d;
  logic            phase_q, phase_d;
`endif

  logic            aw_hs, w_hs, ar_hs, commit;
  logic [2:0]      wr_idx, rd_idx;
  logic [DW-1:0]   wr_data, rd_word;
  logic [SW-1:0]   wr_strb;

  assign S_AXI_AWREADY = en_q && (wstate_q == W_IDLE) && !aw_held_q;
  assign S_AXI_WREADY  = en_q && (wstate_q == W_IDLE) && !w_held_q;
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = en_q && (rstate_q == R_IDLE);
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A beat arriving this cycle is used directly so the commit needs no extra cycle.
  assign wr_idx  = aw_held_q ? awidx_q : S_AXI_AWADDR[4:2];
  assign wr_data = w_held_q  ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_held_q  ? wstrb_q : S_AXI_WSTRB;
  assign commit  = (wstate_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign rd_idx  = S_AXI_ARADDR[4:2];

  // Write FSM: collect AW and W in any order, commit once both are present, then hold B.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = S_AXI_AWADDR[4:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wstate_d  = W_RESP;
          bresp_d   = wr_idx[2] ? 2'b10 : 2'b00;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write channel state and the reset-release enable.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      en_q      <= 1'b0;
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
    end else begin
      en_q      <= 1'b1;
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Register file next state; unmapped indices fall through and change nothing.
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
`ifdef LED_BLINK_EN
    mode_d    = mode_q;
    div_d     = div_q;
`endif
    if (commit) begin
      case (wr_idx)
        3'd0: ctrl_d = apply_strb(ctrl_q, wr_data, wr_strb);
`ifdef LED_BLINK_EN
        3'd1: mode_d = wr_strb[0] ? wr_data[0] : mode_q;
        3'd2: div_d  = apply_strb(div_q, wr_data, wr_strb);
`endif
        3'd3: scratch_d = apply_strb(scratch_q, wr_data, wr_strb);
        default: ;
      endcase
    end
  end

  // Register file storage.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
`ifdef LED_BLINK_EN
      mode_q    <= 1'b0;
      div_q     <= '0;
`endif
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
`ifdef LED_BLINK_EN
      mode_q    <= mode_d;
      div_q     <= div_d;
`endif
    end
  end

  // Read mux samples pre-commit contents, so a same-edge write is not visible to the read.
  always_comb begin
    rd_word = '0;
    case (rd_idx)
      3'd0: rd_word = ctrl_q;
`ifdef LED_BLINK_EN
      3'd1: rd_word = {{(DW-1){1'b0}}, mode_q};
      3'd2: rd_word = div_q;
`endif
      3'd3: rd_word = scratch_q;
      default: rd_word = '0;
    endcase
  end

  // Read FSM: capture data on AR handshake, hold R until RREADY.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d  = rd_word;
          rresp_d  = rd_idx[2] ? 2'b10 : 2'b00;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read channel state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

`ifdef LED_BLINK_EN
  // Blink counter: reload from DIV at zero and flip phase; parked at DIV with phase high when off.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!mode_q) begin
      cnt_d   = div_q;
      phase_d = 1'b1;
    end else if (cnt_q == 32'd0) begin
      cnt_d   = div_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q - 32'd1;
    end
  end

  // Blink counter storage.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign LED = ctrl_q[LED_WIDTH-1:0] & {LED_WIDTH{phase_q}};
`else
  assign LED = ctrl_q[LED_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_led_axil_responder.sv
`timescale 1ns/1ps
// Directed bench for led_axil_responder: register access, strobes, channel ordering,
// unmapped decode, blink gating (build dependent), response hold and async reset.
module tb_led_axil_responder;

  logic        clk;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [3:0]  led;

  int tests = 0;
  int fails = 0;

  logic [31:0] d;
  logic [1:0]  r;
  logic [3:0]  prev_led;
  logic [31:0] hold_data;
  int          n;

  led_axil_responder #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .LED_WIDTH(4)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .LED(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // AW and W presented together; waits for B and completes it.
  task automatic wr(input logic [4:0] a, input logic [31:0] dv, input logic [3:0] s,
                    output logic [1:0] resp);
    int k;
    logic aw_hs, w_hs;
    k = 0;
    awaddr = a; wdata = dv; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && k < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step(); k++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid && k < 20) begin step(); k++; end
    check("wr_bvalid", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    bready = 1'b1; step(); bready = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] dv, output logic [1:0] resp);
    int k;
    k = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && k < 20) begin step(); k++; end
    step(); arvalid = 1'b0;
    check("rd_rvalid_latency", {31'd0, rvalid}, 32'd1);
    dv = rdata; resp = rresp;
    rready = 1'b1; step(); rready = 1'b0;
  endtask

  // One channel leads the other by 3 cycles; B must appear exactly once, 1 cycle after the later beat.
  task automatic wr_split(input logic [4:0] a, input logic [31:0] dv, input bit aw_first);
    awaddr = a; wdata = dv; wstrb = 4'hF;
    if (aw_first) awvalid = 1'b1; else wvalid = 1'b1;
    check("split_first_ready", {31'd0, aw_first ? awready : wready}, 32'd1);
    step(); awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) begin
      check("split_early_bvalid", {31'd0, bvalid}, 32'd0);
      check("split_held_ready", {31'd0, aw_first ? awready : wready}, 32'd0);
      step();
    end
    if (aw_first) wvalid = 1'b1; else awvalid = 1'b1;
    check("split_second_ready", {31'd0, aw_first ? wready : awready}, 32'd1);
    check("split_early_bvalid", {31'd0, bvalid}, 32'd0);
    step(); awvalid = 1'b0; wvalid = 1'b0;
    check("split_bvalid_latency", {31'd0, bvalid}, 32'd1);
    check("split_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1; step(); bready = 1'b0;
    check("split_single_bvalid", {31'd0, bvalid}, 32'd0);
    check("split_ready_back", {30'd0, awready, wready}, 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;

    // Reset state
    step(); step();
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_led", {28'd0, led}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_before_edge", {29'd0, awready, wready, arready}, 32'd0);
    step();
    check("rel_ready_after_edge", {29'd0, awready, wready, arready}, 32'h7);

    // SCRATCH write/read-back
    wr(5'h0C, 32'h0101FFFF, 4'hF, r); check("scr0_bresp", {30'd0, r}, 0);
    rd(5'h0C, d, r); check("scr0_rdata", d, 32'h0101FFFF); check("scr0_rresp", {30'd0, r}, 0);
    wr(5'h0C, 32'hABCD0001, 4'hF, r); check("scr1_bresp", {30'd0, r}, 0);
    rd(5'h0C, d, r); check("scr1_rdata", d, 32'hABCD0001); check("scr1_rresp", {30'd0, r}, 0);
    wr(5'h0C, 32'hDEAD0011, 4'hF, r); check("scr2_bresp", {30'd0, r}, 0);
    rd(5'h0C, d, r); check("scr2_rdata", d, 32'hDEAD0011); check("scr2_rresp", {30'd0, r}, 0);
    wr(5'h0D, 32'hBEEF0011, 4'hF, r); check("scr3_bresp", {30'd0, r}, 0);
    rd(5'h0E, d, r); check("scr3_rdata", d, 32'hBEEF0011); check("scr3_rresp", {30'd0, r}, 0);

    // CTRL byte strobes and LED drive
    wr(5'h00, 32'h0000000A, 4'hF, r);
    check("ctrl_led_a", {28'd0, led}, 32'hA);
    wr(5'h00, 32'h00000005, 4'h1, r);
    check("ctrl_led_5", {28'd0, led}, 32'h5);
    wr(5'h00, 32'hFFFFFFFF, 4'h2, r);
    rd(5'h00, d, r); check("ctrl_strb_merge", d, 32'h0000FF05);
    check("ctrl_led_kept", {28'd0, led}, 32'h5);

    // Channel ordering
    wr_split(5'h0C, 32'h11111111, 1'b1);
    rd(5'h0C, d, r); check("aw_first_data", d, 32'h11111111);
    wr_split(5'h0C, 32'h22222222, 1'b0);
    rd(5'h0C, d, r); check("w_first_data", d, 32'h22222222);
    awaddr = 5'h0C; wdata = 32'h33333333; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    step(); awvalid = 0; wvalid = 0;
    check("same_cycle_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1; step(); bready = 0;
    check("same_cycle_single_b", {31'd0, bvalid}, 32'd0);
    rd(5'h0C, d, r); check("same_cycle_data", d, 32'h33333333);

    // Unmapped decode
    wr(5'h14, 32'h12345678, 4'hF, r); check("unmap_w14_bresp", {30'd0, r}, 32'd2);
    wr(5'h1C, 32'hDEADBEEF, 4'hF, r); check("unmap_w1c_bresp", {30'd0, r}, 32'd2);
    rd(5'h1C, d, r); check("unmap_r1c_rdata", d, 0); check("unmap_r1c_rresp", {30'd0, r}, 32'd2);
    rd(5'h14, d, r); check("unmap_r14_rdata", d, 0); check("unmap_r14_rresp", {30'd0, r}, 32'd2);
    rd(5'h0C, d, r); check("unmap_scratch_kept", d, 32'h33333333);
    rd(5'h00, d, r); check("unmap_ctrl_kept", d, 32'h0000FF05);
    rd(5'h04, d, r); check("unmap_mode_kept", d, 0);

    // Blink engine
    wr(5'h00, 32'h0000000F, 4'hF, r);
    wr(5'h08, 32'h00000003, 4'hF, r);
`ifdef LED_BLINK_EN
    wr(5'h04, 32'h00000001, 4'hF, r); check("blink_mode_bresp", {30'd0, r}, 0);
    n = 0;
    while (led == 4'hF && n < 20) begin step(); n++; end
    check("blink_first_off", {28'd0, led}, 32'h0);
    repeat (3) begin step(); check("blink_off", {28'd0, led}, 32'h0); end
    repeat (4) begin step(); check("blink_on", {28'd0, led}, 32'hF); end
    step(); check("blink_off_again", {28'd0, led}, 32'h0);
    rd(5'h04, d, r); check("blink_mode_rd", d, 32'd1);
    rd(5'h08, d, r); check("blink_div_rd", d, 32'd3);
    wr(5'h08, 32'h00000000, 4'hF, r);
    repeat (8) step();
    prev_led = led;
    repeat (4) begin
      step();
      check("blink_div0_toggle", {28'd0, led}, {28'd0, prev_led ^ 4'hF});
      prev_led = led;
    end
    wr(5'h04, 32'h00000000, 4'hF, r);
    check("blink_off_led", {28'd0, led}, 32'hF);
`else
    wr(5'h04, 32'h00000001, 4'hF, r); check("noblink_mode_bresp", {30'd0, r}, 0);
    rd(5'h04, d, r); check("noblink_mode_rd", d, 0); check("noblink_mode_rresp", {30'd0, r}, 0);
    rd(5'h08, d, r); check("noblink_div_rd", d, 0); check("noblink_div_rresp", {30'd0, r}, 0);
    repeat (10) begin step(); check("noblink_led", {28'd0, led}, 32'hF); end
`endif

    // Response hold under backpressure; same-edge write and read of SCRATCH
    awaddr = 5'h0C; wdata = 32'h55AA55AA; wstrb = 4'hF; araddr = 5'h0C;
    awvalid = 1; wvalid = 1; arvalid = 1;
    step(); awvalid = 0; wvalid = 0; arvalid = 0;
    hold_data = 32'h33333333;
    check("hold_old_value", rdata, hold_data);
    repeat (10) begin
      check("hold_bvalid", {31'd0, bvalid}, 32'd1);
      check("hold_rvalid", {31'd0, rvalid}, 32'd1);
      check("hold_rdata", rdata, hold_data);
      step();
    end

    // Asynchronous reset mid-hold
    #2 rst_n = 1'b0;
    #1;
    check("arst_bvalid", {31'd0, bvalid}, 32'd0);
    check("arst_rvalid", {31'd0, rvalid}, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    check("arst_led", {28'd0, led}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_no_b", {31'd0, bvalid}, 32'd0);
      check("post_rst_no_r", {31'd0, rvalid}, 32'd0);
    end
    rd(5'h0C, d, r); check("post_rst_scratch", d, 32'd0);
    rd(5'h00, d, r); check("post_rst_ctrl", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
